// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared state encoding and counter width for the SPI transfer scheduler
package spi_sched_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } sched_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter (bit0 = write, bit1 = read)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // Reset value "read was last" makes write win the first tie.
  logic last_rd_q, last_rd_d;

  always_comb begin
    gnt_o     = 2'b00;
    last_rd_d = last_rd_q;
    if (req_i[0] && (!req_i[1] || last_rd_q)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
    if (en_i && (gnt_o != 2'b00)) begin
      last_rd_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_rd_q <= 1'b1;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// rtl/spi_xfer_sched.sv - arbitrates write/read requesters onto one SPI master core with cs_n framing
module spi_xfer_sched
  import spi_sched_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CS_NUM      = 4,
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int GAP_CYC     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_req,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [$clog2(CS_NUM)-1:0] wr_cs_sel,
  input  logic                      rd_req,
  input  logic [$clog2(CS_NUM)-1:0] rd_cs_sel,
  output logic                      wr_gnt,
  output logic                      rd_gnt,
  output logic                      wr_done,
  output logic                      rd_done,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      err,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_tx_data,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_rx_data,
  output logic [CS_NUM-1:0]         cs_n
);

  localparam int SEL_W = $clog2(CS_NUM);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              is_rd_q, is_rd_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [CS_NUM-1:0] cs_n_q, cs_n_d;
  logic              wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
  logic              wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic              err_q, err_d, start_q, start_d;
  logic [1:0]        arb_gnt;
  logic [SEL_W-1:0]  sel;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({rd_req, wr_req}),
    .en_i  (state_q == IDLE),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    is_rd_d   = is_rd_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rd_data_d = rd_data_q;
    cs_n_d    = cs_n_q;
    wr_gnt_d  = 1'b0;
    rd_gnt_d  = 1'b0;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    err_d     = 1'b0;
    start_d   = 1'b0;
    sel       = arb_gnt[1] ? rd_cs_sel : wr_cs_sel;

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          is_rd_d  = arb_gnt[1];
          wr_gnt_d = arb_gnt[0];
          rd_gnt_d = arb_gnt[1];
          tx_d     = arb_gnt[1] ? '0 : wr_data;
          for (int i = 0; i < CS_NUM; i++) begin
            cs_n_d[i] = (sel != SEL_W'(i));
          end
          cnt_d   = CNT_W'(SETUP_CYC);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_ONE) begin
          start_d = 1'b1;
          tmo_d   = TMO_ONE;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      XFER: begin
        // tmo_q counts XFER cycles including the current one; done wins a same-cycle timeout.
        if (core_done) begin
          rx_d    = core_rx_data;
          cnt_d   = CNT_W'(HOLD_CYC);
          state_d = HOLD;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
          err_d   = 1'b1;
          cs_n_d  = '1;
          cnt_d   = CNT_W'(GAP_CYC);
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_ONE) begin
          cs_n_d = '1;
          if (is_rd_q) begin
            rd_done_d = 1'b1;
            rd_data_d = rx_q;
          end else begin
            wr_done_d = 1'b1;
          end
          cnt_d   = CNT_W'(GAP_CYC);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      is_rd_q   <= 1'b0;
      rx_q      <= '0;
      tx_q      <= '0;
      rd_data_q <= '0;
      cs_n_q    <= '1;
      wr_gnt_q  <= 1'b0;
      rd_gnt_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      is_rd_q   <= is_rd_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rd_data_q <= rd_data_d;
      cs_n_q    <= cs_n_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_gnt_q  <= rd_gnt_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      err_q     <= err_d;
      start_q   <= start_d;
    end
  end

  assign wr_gnt       = wr_gnt_q;
  assign rd_gnt       = rd_gnt_q;
  assign wr_done      = wr_done_q;
  assign rd_done      = rd_done_q;
  assign rd_data      = rd_data_q;
  assign err          = err_q;
  assign core_start   = start_q;
  assign core_tx_data = tx_q;
  assign cs_n         = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb/tb_spi_xfer_sched.sv - directed self-checking bench for spi_xfer_sched
module tb_spi_xfer_sched;
  import spi_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req;
  logic [31:0] wr_data;
  logic [1:0]  wr_cs_sel, rd_cs_sel;
  logic        wr_gnt, rd_gnt, wr_done, rd_done, err, core_start, core_done;
  logic [31:0] rd_data, core_tx_data, core_rx_data;
  logic [3:0]  cs_n;

  int checks = 0;
  int errors = 0;
  logic        is_w;
  logic [31:0] last_rd;
  logic [3:0]  exp_cs;

  always #5 clk = ~clk;

  spi_xfer_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .wr_cs_sel    (wr_cs_sel),
    .rd_req       (rd_req),
    .rd_cs_sel    (rd_cs_sel),
    .wr_gnt       (wr_gnt),
    .rd_gnt       (rd_gnt),
    .wr_done      (wr_done),
    .rd_done      (rd_done),
    .rd_data      (rd_data),
    .err          (err),
    .core_start   (core_start),
    .core_tx_data (core_tx_data),
    .core_done    (core_done),
    .core_rx_data (core_rx_data),
    .cs_n         (cs_n)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    wr_cs_sel = '0; rd_cs_sel = '0; core_done = 1'b0; core_rx_data = '0;
    tick(2);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_gnt", 32'({wr_gnt, rd_gnt}), 32'h0);
    chk("rst_done_err", 32'({wr_done, rd_done, err, core_start}), 32'h0);
    chk("rst_tx", core_tx_data, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // single write to slave 2
    wr_req = 1'b1; wr_data = 32'hA5A5_0F0F; wr_cs_sel = 2'd2;
    tick();
    chk("wr_gnt", 32'(wr_gnt), 32'h1);
    chk("wr_gnt_rd", 32'(rd_gnt), 32'h0);
    chk("wr_setup_cs", 32'(cs_n), 32'hB);
    chk("wr_setup_state", 32'(dut.state_q), 32'(SETUP));
    wr_req = 1'b0; wr_data = '0;
    tick();
    chk("wr_gnt_pulse", 32'(wr_gnt), 32'h0);
    chk("wr_setup2_cs", 32'(cs_n), 32'hB);
    chk("wr_setup2_start", 32'(core_start), 32'h0);
    tick();
    chk("wr_start", 32'(core_start), 32'h1);
    chk("wr_tx", core_tx_data, 32'hA5A5_0F0F);
    chk("wr_xfer_state", 32'(dut.state_q), 32'(XFER));
    tick();
    chk("wr_start_pulse", 32'(core_start), 32'h0);
    core_done = 1'b1; core_rx_data = 32'hDEAD_BEEF;
    tick();
    core_done = 1'b0;
    chk("wr_hold_state", 32'(dut.state_q), 32'(HOLD));
    chk("wr_hold_cs", 32'(cs_n), 32'hB);
    tick();
    chk("wr_hold2_done", 32'(wr_done), 32'h0);
    tick();
    chk("wr_done", 32'(wr_done), 32'h1);
    chk("wr_done_rd", 32'(rd_done), 32'h0);
    chk("wr_done_cs", 32'(cs_n), 32'hF);
    chk("wr_rd_data_kept", rd_data, 32'h0);
    chk("wr_gap_state", 32'(dut.state_q), 32'(GAP));
    tick();
    chk("wr_done_pulse", 32'(wr_done), 32'h0);
    tick(2);
    chk("wr_idle", 32'(dut.state_q), 32'(IDLE));

    // single read from slave 1
    rd_req = 1'b1; rd_cs_sel = 2'd1;
    tick();
    chk("rd_gnt", 32'({wr_gnt, rd_gnt}), 32'h1);
    chk("rd_setup_cs", 32'(cs_n), 32'hD);
    rd_req = 1'b0;
    tick(2);
    chk("rd_start", 32'(core_start), 32'h1);
    chk("rd_tx_zero", core_tx_data, 32'h0);
    core_done = 1'b1; core_rx_data = 32'h1234_5678;
    tick();
    core_done = 1'b0; core_rx_data = '0;
    chk("rd_hold_state", 32'(dut.state_q), 32'(HOLD));
    chk("rd_hold_cs", 32'(cs_n), 32'hD);
    tick();
    chk("rd_hold2_cs", 32'(cs_n), 32'hD);
    chk("rd_hold2_done", 32'(rd_done), 32'h0);
    tick();
    chk("rd_done", 32'(rd_done), 32'h1);
    chk("rd_data", rd_data, 32'h1234_5678);
    chk("rd_done_cs", 32'(cs_n), 32'hF);

    // spurious core_done in GAP and IDLE
    core_done = 1'b1; core_rx_data = 32'hFFFF_FFFF;
    tick();
    chk("spur_gap_state", 32'(dut.state_q), 32'(GAP));
    chk("spur_gap_rd_data", rd_data, 32'h1234_5678);
    chk("spur_gap_done", 32'(rd_done), 32'h0);
    tick(2);
    chk("spur_idle_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk("spur_idle_state2", 32'(dut.state_q), 32'(IDLE));
    chk("spur_idle_rd_data", rd_data, 32'h1234_5678);
    chk("spur_idle_start", 32'(core_start), 32'h0);
    core_done = 1'b0; core_rx_data = '0;

    // both requesters held: expect W,R,W,R with fixed gap
    last_rd = 32'h1234_5678;
    wr_cs_sel = 2'd0; rd_cs_sel = 2'd3;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      is_w = (k % 2 == 0);
      exp_cs = is_w ? 4'hE : 4'h7;
      wr_data = 32'h5000_0000 + 32'(k);
      tick();
      chk($sformatf("tie%0d_wr_gnt", k), 32'(wr_gnt), 32'(is_w));
      chk($sformatf("tie%0d_rd_gnt", k), 32'(rd_gnt), 32'(!is_w));
      if (k == 3) begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
      tick(2);
      chk($sformatf("tie%0d_start", k), 32'(core_start), 32'h1);
      chk($sformatf("tie%0d_tx", k), core_tx_data, is_w ? (32'h5000_0000 + 32'(k)) : 32'h0);
      core_done = 1'b1; core_rx_data = 32'h1000_0000 + 32'(k);
      tick();
      core_done = 1'b0;
      chk($sformatf("tie%0d_cs", k), 32'(cs_n), 32'(exp_cs));
      tick(2);
      chk($sformatf("tie%0d_wr_done", k), 32'(wr_done), 32'(is_w));
      chk($sformatf("tie%0d_rd_done", k), 32'(rd_done), 32'(!is_w));
      if (!is_w) last_rd = 32'h1000_0000 + 32'(k);
      chk($sformatf("tie%0d_rd_data", k), rd_data, last_rd);
      for (int g = 0; g < 3; g++) begin
        tick();
        chk($sformatf("tie%0d_gap%0d_gnt", k, g), 32'({wr_gnt, rd_gnt}), 32'h0);
      end
      chk($sformatf("tie%0d_idle", k), 32'(dut.state_q), 32'(IDLE));
    end

    // timeout: core_done never arrives
    wr_req = 1'b1; wr_cs_sel = 2'd0; wr_data = 32'hCAFE_0001;
    tick();
    chk("to_gnt", 32'(wr_gnt), 32'h1);
    wr_req = 1'b0;
    tick(2);
    chk("to_start", 32'(core_start), 32'h1);
    tick(1023);
    chk("to_no_err_early", 32'(err), 32'h0);
    chk("to_still_xfer", 32'(dut.state_q), 32'(XFER));
    tick();
    chk("to_err", 32'(err), 32'h1);
    chk("to_cs", 32'(cs_n), 32'hF);
    chk("to_no_done", 32'({wr_done, rd_done}), 32'h0);
    chk("to_gap", 32'(dut.state_q), 32'(GAP));
    tick();
    chk("to_err_pulse", 32'(err), 32'h0);
    chk("to_no_done2", 32'({wr_done, rd_done}), 32'h0);
    tick(2);
    chk("to_idle", 32'(dut.state_q), 32'(IDLE));

    // reset mid-XFER, then tie must go to write again
    wr_req = 1'b1; wr_cs_sel = 2'd3; wr_data = 32'h0BAD_F00D;
    tick();
    wr_req = 1'b0;
    tick(2);
    chk("rx_xfer", 32'(dut.state_q), 32'(XFER));
    tick(5);
    rst_n = 1'b0;
    tick();
    chk("rx_cs", 32'(cs_n), 32'hF);
    chk("rx_state", 32'(dut.state_q), 32'(IDLE));
    chk("rx_no_pulse", 32'({wr_done, rd_done, err, core_start}), 32'h0);
    rst_n = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    chk("rx_tie_wr", 32'(wr_gnt), 32'h1);
    chk("rx_tie_rd", 32'(rd_gnt), 32'h0);
    wr_req = 1'b0; rd_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
